// File: rtl/fetch_queue.sv
// fetch_queue: PC register, 1-cycle instruction-memory request/response and a
// DEPTH-entry {pc,instr} prefetch FIFO presented to decode over valid/ready.
//   clk, rst (async, active-high)        enable: global step
//   redirect, redirect_target            flush queue, restart fetch at target
//   imem_req, imem_addr, imem_rdata      synchronous memory, data one cycle later
//   out_valid, out_ready, out_pc/instr   head of queue to decode
//   count, pc                            occupancy and next fetch PC
// Optional FETCH_PERF_EN: perf_fetched (pushes), perf_flushed (entries dropped).
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_target,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH):0]     count,
`ifdef FETCH_PERF_EN
  output logic [XLEN-1:0]            pc,
  output logic [31:0]                perf_fetched,
  output logic [31:0]                perf_flushed
`else
  output logic [XLEN-1:0]            pc
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d;
  logic            inflight_q, inflight_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     ins_mem [DEPTH];
  logic            pop, push;
  logic [CW:0]     used;
  assign pop  = enable & (count_q != '0) & out_ready & ~redirect;
  // a redirect in the same cycle kills the arriving response
  assign push = inflight_q & ~redirect;
  // slots already promised: held entries plus the outstanding response, less this pop
  assign used = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  // gated by rst so the request drops the moment reset asserts
  assign imem_req  = ~rst & enable & ~redirect & (used < (CW+1)'(DEPTH));
  assign imem_addr = pc_q;
  assign out_valid = count_q != '0;
  assign out_pc    = pc_mem[rd_q];
  assign out_instr = ins_mem[rd_q];
  assign count     = count_q;
  assign pc        = pc_q;
  always_comb begin
    pc_d       = redirect ? redirect_target & ~XLEN'(3) : imem_req ? pc_q + XLEN'(4) : pc_q;
    addr_d     = imem_req ? pc_q : addr_q;
    inflight_d = imem_req;
    rd_d       = redirect ? '0 : rd_q + AW'(pop);
    wr_d       = redirect ? '0 : wr_q + AW'(push);
    count_d    = redirect ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      inflight_q <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
    end
  end
  // storage needs no reset: entries are only visible while count covers them
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]  <= addr_q;
      ins_mem[wr_q] <= imem_rdata;
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_flushed_q;
  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_q + 32'(push);
      perf_flushed_q <= redirect ? perf_flushed_q + 32'(count_q) + 32'(inflight_q) : perf_flushed_q;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a queue-based model
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        redirect = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, imem_rdata, out_pc, out_instr, pc;
  logic [2:0]  count;
  logic [31:0] mem_addr = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif
  int checks = 0;
  int errors = 0;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t        q[$];
  logic [31:0] m_pc, m_addr, m_fet, m_flu;
  bit          m_inf;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .count(count), .pc(pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // synchronous instruction memory: word for the address requested last cycle
  always @(posedge clk) if (imem_req) mem_addr <= imem_addr;
  assign imem_rdata = mem_word(mem_addr);

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_pc = 32'h0; m_addr = 32'h0; m_inf = 0; m_fet = 0; m_flu = 0;
  endtask

  // entered and left at a negedge; rst rises strictly between edges
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fet", perf_fetched, 0);
    chk("rst_perf_flu", perf_flushed, 0);
`endif
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one cycle: drive inputs, compare against model, advance model at the edge
  task automatic step(bit en, bit rd, bit rdr, logic [31:0] tgt);
    bit pop, req;
    enable = en; out_ready = rd; redirect = rdr; redirect_target = tgt;
    #1;
    pop = en && q.size() != 0 && rd && !rdr;
    req = en && !rdr && (q.size() + int'(m_inf) - int'(pop) < 4);
    chk("imem_req", imem_req, req);
    if (req) chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].ins);
    end
    chk("count", count, q.size());
    chk("pc", pc, m_pc);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fet);
    chk("perf_flushed", perf_flushed, m_flu);
`endif
    if (rdr) begin
      m_flu += q.size() + int'(m_inf);
      q.delete();
      m_inf = 0;
      m_pc = {tgt[31:2], 2'b00};
    end else begin
      if (pop) void'(q.pop_front());
      if (m_inf) begin
        q.push_back('{pc: m_addr, ins: mem_word(m_addr)});
        m_fet++;
      end
      m_inf = req;
      if (req) begin
        m_addr = m_pc;
        m_pc += 4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // streaming: one entry per cycle from cycle 2
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_pc0", out_pc, 32'h0);
    chk("t1_instr0", out_instr, 32'hC0DE_0000);
    chk("t1_count", count, 1);
    step(1, 1, 0, 0);
    chk("t1_pc1", out_pc, 32'h4);
    // enable low with a response in flight: it lands, everything else holds
    repeat (5) step(0, 1, 0, 0);
    chk("t5_count", count, 2);
    chk("t5_head", out_pc, 32'h4);
    chk("t5_pc", pc, 32'hC);
    step(1, 1, 0, 0);
    chk("t5_resume", pc, 32'h10);
    // redirect together with a pop and a push
    step(1, 1, 1, 32'h40);
    chk("t4_count", count, 0);
    chk("t4_valid", out_valid, 0);
    chk("t4_pc", pc, 32'h40);
    // redirect with 3 entries plus one in flight
    do_reset();
    repeat (4) step(1, 0, 0, 0);
    chk("t3_pre_count", count, 3);
    step(1, 0, 1, 32'h103);
    chk("t3_count", count, 0);
    chk("t3_pc", pc, 32'h100);
`ifdef FETCH_PERF_EN
    chk("t3_flushed", perf_flushed, 4);
`endif
    step(1, 0, 0, 0);
    chk("t3_valid_n2", out_valid, 0);
    step(1, 0, 0, 0);
    chk("t3_valid_n3", out_valid, 1);
    chk("t3_pc_n3", out_pc, 32'h100);
    chk("t3_instr_n3", out_instr, 32'hC0DE_0100);
    // back-pressure to full, then drain in order
    do_reset();
    repeat (5) step(1, 0, 0, 0);
    chk("t2_full", count, 4);
    chk("t2_req_off", imem_req, 0);
    chk("t2_pc", pc, 32'h10);
    for (int i = 0; i < 5; i++) begin
      chk("t2_drain", out_pc, 32'(4 * i));
      step(1, 1, 0, 0);
    end
    // pc wraps at the top of the address space
    step(1, 1, 1, 32'hFFFF_FFFE);
    chk("wrap_tgt", pc, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    chk("wrap_pc", pc, 32'h0);
    // random traffic with occasional redirects and mid-stream resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
